ifmap_stream_writer: RTL and testbench

Producer end of the IFMap buffer write interface. Reads an input feature map row by row from a linear word memory. Tags each word with end-of-row and end-of-map flags and pushes it into the IFMap FIFO using wen_IFMap_buffer, honouring FIFO backpressure. It sits between the IFMap memory and the dp IFMap_in / wen_IFMap_buffer ports.

---
 rtl/ifmap_stream_writer.sv | 160 ++++++++++++++++
 tb/tb_ifmap_stream_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_stream_writer.sv
// IFMap stream writer: reads a feature map row by row from word memory, tags words with
// end-of-row/end-of-map flags and pushes them into the IFMap FIFO. Optional macro: IFMAP_ZERO_PAD_EN.
module ifmap_stream_writer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 12,
  parameter int ROW_LEN_WIDTH = 8,
  parameter int ROW_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ROW_LEN_WIDTH-1:0] row_len,
  input  logic [ROW_CNT_WIDTH-1:0] row_count,
`ifdef IFMAP_ZERO_PAD_EN
  input  logic                     pad_en,
`endif
  output logic                     mem_ren,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     fifo_full,
  output logic [DATA_WIDTH+1:0]    IFMap_out,
  output logic                     wen_IFMap_buffer,
  output logic                     busy,
  output logic                     done
);

  localparam int WORD_W = DATA_WIDTH + 2;
  localparam int COL_W  = ROW_LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]    addr_cnt;
  logic [COL_W-1:0]         col_cnt;
  logic [ROW_CNT_WIDTH-1:0] row_cnt;
  logic [ROW_LEN_WIDTH-1:0] row_len_q;
  logic [ROW_CNT_WIDTH-1:0] row_count_q;
  logic                     pad_q;
  logic                     busy_q;

  logic                     vld_p1, eor_p1, eom_p1, zero_p1;
  logic                     hold_vld;
  logic [WORD_W-1:0]        hold_word;
  logic [WORD_W-1:0]        last_out;

  logic                     issue, pad_col, eor_p0, eom_p0, wen, empty_req;
  logic [COL_W-1:0]         last_col;
  logic [WORD_W-1:0]        ret_word, wr_word;

`ifdef IFMAP_ZERO_PAD_EN
  always_ff @(posedge clk) begin
    if (rst)
      pad_q <= 1'b0;
    else if (state == IDLE && start)
      pad_q <= pad_en;
  end
`else
  assign pad_q = 1'b0;
`endif

  // Issue stage (p0): read/pad decision and flags for the word being requested
  always_comb begin
    empty_req = (row_len == '0) || (row_count == '0);
    last_col  = pad_q ? COL_W'(row_len_q) + COL_W'(1) : COL_W'(row_len_q) - COL_W'(1);
    pad_col   = pad_q && ((col_cnt == '0) || (col_cnt == last_col));
    eor_p0    = (col_cnt == last_col);
    eom_p0    = eor_p0 && (row_cnt == row_count_q - ROW_CNT_WIDTH'(1));
    issue     = (state == STREAM) && !fifo_full && !hold_vld;
    wen       = !fifo_full && (hold_vld || vld_p1);
    ret_word  = {eom_p1, eor_p1, (zero_p1 ? {DATA_WIDTH{1'b0}} : mem_rdata)};
    wr_word   = hold_vld ? hold_word : ret_word;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // An empty transfer passes through DRAIN so its done pulse lines up with the streaming case
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = empty_req ? DRAIN : STREAM;
      STREAM:  if (issue && eom_p0) state_nxt = DRAIN;
      DRAIN:   if (wen || !(vld_p1 || hold_vld)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ren          = issue && !pad_col;
    mem_addr         = addr_cnt;
    wen_IFMap_buffer = wen;
    IFMap_out        = wen ? wr_word : last_out;
    busy             = busy_q;
    done             = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt    <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      row_len_q   <= '0;
      row_count_q <= '0;
      busy_q      <= 1'b0;
      vld_p1      <= 1'b0;
      eor_p1      <= 1'b0;
      eom_p1      <= 1'b0;
      zero_p1     <= 1'b0;
      hold_vld    <= 1'b0;
      hold_word   <= '0;
      last_out    <= '0;
    end else begin
      if (state == IDLE && start) begin
        row_len_q   <= row_len;
        row_count_q <= row_count;
        addr_cnt    <= base_addr;
        col_cnt     <= '0;
        row_cnt     <= '0;
        busy_q      <= !empty_req;
      end else begin
        if (issue) begin
          if (!pad_col)
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
          if (eor_p0) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + ROW_CNT_WIDTH'(1);
          end else begin
            col_cnt <= col_cnt + COL_W'(1);
          end
        end
        if (state_nxt == FIN)
          busy_q <= 1'b0;
      end

      // Return stage (p1): memory data arrives; flags travel alongside
      vld_p1  <= issue;
      eor_p1  <= eor_p0;
      eom_p1  <= eom_p0;
      zero_p1 <= pad_col;

      // A returning word blocked by a full FIFO parks here; issue stalls until it drains
      if (vld_p1 && fifo_full) begin
        hold_vld  <= 1'b1;
        hold_word <= ret_word;
      end else if (hold_vld && !fifo_full) begin
        hold_vld <= 1'b0;
      end

      if (wen)
        last_out <= wr_word;
    end
  end

endmodule

// File: tb/tb_ifmap_stream_writer.sv
// Scoreboard bench for ifmap_stream_writer: expected words and read addresses are queued at
// start and popped as the DUT reads memory and writes the FIFO.
module tb_ifmap_stream_writer;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    row_len = '0;
  logic [7:0]    row_count = '0;
  logic          pad_en = 1'b0;
  logic          mem_ren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          fifo_full = 1'b0;
  logic [DW+1:0] IFMap_out;
  logic          wen_IFMap_buffer;
  logic          busy;
  logic          done;

  ifmap_stream_writer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .row_len          (row_len),
    .row_count        (row_count),
`ifdef IFMAP_ZERO_PAD_EN
    .pad_en           (pad_en),
`endif
    .mem_ren          (mem_ren),
    .mem_addr         (mem_addr),
    .mem_rdata        (mem_rdata),
    .fifo_full        (fifo_full),
    .IFMap_out        (IFMap_out),
    .wen_IFMap_buffer (wen_IFMap_buffer),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int first_wr_cyc, last_wr_cyc, done_cyc;
  bit done_seen, busy_seen, first_seen;
  logic [DW+1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (wen_IFMap_buffer) begin
        chk("wen_while_full", {31'b0, fifo_full}, 32'd0);
        chk("write_expected", {31'b0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("word", 32'(IFMap_out), 32'(exp_q.pop_front()));
        wr_cnt++;
        if (!first_seen) begin
          first_seen   = 1'b1;
          first_wr_cyc = cyc;
        end
        last_wr_cyc = cyc;
      end
      if (mem_ren) begin
        chk("read_expected", {31'b0, addr_q.size() > 0}, 32'd1);
        if (addr_q.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (done) begin
        chk("busy_in_fin", {31'b0, busy}, 32'd0);
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic push_expect(input int base, input int rl, input int rc, input bit pad);
    int a = base;
    for (int r = 0; r < rc; r++) begin
      bit last_row = (r == rc - 1);
      if (pad && rl > 0) exp_q.push_back({2'b00, 16'h0});
      for (int c = 0; c < rl; c++) begin
        bit eor = !pad && (c == rl - 1);
        addr_q.push_back(AW'(a));
        exp_q.push_back({eor && last_row, eor, mem[a % (1 << AW)]});
        a = (a + 1) % (1 << AW);
      end
      if (pad && rl > 0) exp_q.push_back({last_row, 1'b1, 16'h0});
    end
  endtask

  // Drives one transfer; full_at >= 0 raises fifo_full for 3 cycles starting full_at cycles after start
  task automatic run_xfer(input int base, input int rl, input int rc, input bit pad,
                          input int full_at, output int s_cyc);
    push_expect(base, rl, rc, pad);
    done_seen = 0; busy_seen = 0; first_seen = 0;
    @(posedge clk); #1;
    base_addr = AW'(base); row_len = 8'(rl); row_count = 8'(rc); pad_en = pad;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300 && !done_seen; k++) begin
      fifo_full = (full_at >= 0) && (cyc >= s_cyc + full_at) && (cyc < s_cyc + full_at + 3);
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;
    chk("done_seen", {31'b0, done_seen}, 32'd1);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("addr_q_empty", addr_q.size(), 32'd0);
  endtask

  initial begin
    int s;
    int saved;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    mem[12'h020] = 16'd5;
    mem[12'h021] = 16'd6;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out", 32'(IFMap_out), 32'd0);
    chk("rst_wen", {31'b0, wen_IFMap_buffer}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;

    // 4x2 transfer, no backpressure
    run_xfer(12'h010, 4, 2, 0, -1, s);
    chk("t1_first_wr_lat", first_wr_cyc - s, 32'd2);
    chk("t1_done_lat", done_cyc - last_wr_cyc, 32'd1);
    chk("t1_busy_seen", {31'b0, busy_seen}, 32'd1);
    chk("t1_out_hold", 32'(IFMap_out), 32'h30017);

    // Same transfer, FIFO full for 3 cycles from the third return
    saved = wr_cnt;
    run_xfer(12'h010, 4, 2, 0, 4, s);
    chk("t2_write_count", wr_cnt - saved, 32'd8);
    chk("t2_done_lat", done_cyc - last_wr_cyc, 32'd1);

    // Empty transfer
    saved = wr_cnt;
    run_xfer(12'h010, 0, 2, 0, -1, s);
    chk("t3_no_write", wr_cnt - saved, 32'd0);
    chk("t3_done_lat", done_cyc - s, 32'd2);
    chk("t3_busy_never", {31'b0, busy_seen}, 32'd0);

    // Address wrap
    run_xfer(12'hFFE, 3, 1, 0, -1, s);
    chk("t4_done_lat", done_cyc - last_wr_cyc, 32'd1);

    // Reset after the third write abandons the transfer
    push_expect(12'h010, 4, 2, 0);
    saved = wr_cnt;
    @(posedge clk); #1;
    base_addr = 12'h010; row_len = 8'd4; row_count = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50 && (wr_cnt - saved) < 3; k++) @(negedge clk);
    chk("t5_three_writes", wr_cnt - saved, 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    addr_q.delete();
    chk("t5_mem_ren", {31'b0, mem_ren}, 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_out", 32'(IFMap_out), 32'd0);
    chk("t5_wen", {31'b0, wen_IFMap_buffer}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    saved = wr_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_write_after_rst", wr_cnt - saved, 32'd0);
    run_xfer(12'h010, 4, 2, 0, -1, s);
    chk("t5_restart_first_lat", first_wr_cyc - s, 32'd2);

`ifdef IFMAP_ZERO_PAD_EN
    saved = wr_cnt;
    run_xfer(12'h020, 2, 1, 1, -1, s);
    chk("t6_write_count", wr_cnt - saved, 32'd4);
    chk("t6_out_hold", 32'(IFMap_out), 32'h30000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
